fp_entry_ctrl: RTL and testbench
================================

// Module: fp_entry_ctrl
// PURPOSE
//  Operator-entry sequencer for the half-precision adder. Takes decoded keypad
//  digit strobes plus enter/clear buttons. Assembles operand A, then operand B,
//  as DIGITS hex nibbles each. Launches the adder with a start/done handshake,
//  then holds the sum for display. Sits between the keypad front end and the
//  FP adder core, and drives the display word.
// PARAMETERS
//  DIGITS   4    hex nibbles per operand; W = DIGITS*4 (16 for binary16)
//  TIMEOUT  64   max cycles to wait for add_done before flagging an error
// PORTS
//  clk        in   1   single system clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  key_valid  in   1   one-cycle strobe: key_value holds a new digit
//  key_value  in   4   hex digit 0x0-0xF
//  enter      in   1   one-cycle strobe (debounced upstream)
//  clear      in   1   one-cycle strobe (debounced upstream)
//  add_start  out  1   one-cycle pulse launching the adder
//  add_a      out  W   operand A; stable from add_start until done/timeout
//  add_b      out  W   operand B; same stability rule
//  add_done   in   1   one-cycle pulse: add_sum valid this cycle
//  add_sum    in   W   adder result
//  display    out  W   word for the 7-seg/LED display
//  mode       out  2   current state: 0=ENT_A 1=ENT_B 2=WAIT 3=SHOW
//  busy       out  1   1 while in WAIT
//  err        out  1   sticky timeout flag
// BEHAVIOUR
//  Reset: state=ENT_A; A, B and result regs = 0; all outputs 0.
//  Digit capture (ENT_A/ENT_B): on key_valid, the active operand reg <= {reg[W-5:0], key_value}.
//   - shift-register entry; a 5th+ digit pushes the oldest nibble out
//  display: ENT_A shows A; ENT_B shows B; WAIT shows B; SHOW shows result.
//  ENT_A: on enter -> ENT_B, B cleared to 0. Enter with no digits is legal (operand = 0).
//  ENT_B: on enter -> WAIT; add_start=1 on the cycle the state becomes WAIT (registered).
//  WAIT:
//   - key_valid and enter ignored
//   - cycle counter starts at 0 on entry
//   - add_done -> result <= add_sum; go to SHOW next cycle (display updates then)
//   - counter reaches TIMEOUT-1 without done -> result <= 16'h7E00 (qNaN), err=1, go to SHOW
//   - done and timeout in the same cycle: done wins, err unchanged
//  SHOW:
//   - key_valid -> ENT_A, with A <= {0..., key_value} (the new entry starts with that digit)
//   - enter -> WAIT with a new add_start, re-running the same A and B
//  add_done outside WAIT is ignored.
//  clear (any state, including mid-WAIT) -> ENT_A next cycle; A, B, result and err
//  all zeroed; a pending add is abandoned and its late done is ignored.
//  Same-cycle priority: clear > enter > key_valid.
//   - key_valid+enter in ENT_A/ENT_B: the digit is captured first, then the transition
//     uses the updated operand
//  err is cleared only by clear or reset.
// TESTING
//  1. reset, keys 3,C,0,0, enter, keys 4,0,0,0, enter -> add_a=3C00, add_b=4000,
//     add_start high exactly 1 cycle, mode=2.
//  2. Case 1, then add_done with add_sum=4500 -> next cycle mode=3, display=4500, busy=0.
//  3. Enter digits 1,2,3,4,5 in ENT_A -> display=2345.
//  4. WAIT with no add_done for 64 cycles -> err=1, display=7E00, mode=3;
//     then clear -> err=0, mode=0, display=0000.
//  5. In SHOW, press enter -> second add_start with unchanged add_a/add_b;
//     key 7 in SHOW -> mode=0, display=0007.
//  6. clear asserted the same cycle as add_done in WAIT -> mode=0, result stays 0;
//     a later add_done is ignored.

Source files
------------

// File: rtl/fp_entry_ctrl.sv
// fp_entry_ctrl
//   Operator-entry sequencer for the half-precision adder. Assembles operand A
//   and then operand B from keypad hex digits, launches the adder with a
//   start/done handshake, and holds the sum for display.
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   key_valid, key_value  digit strobe and its hex value
//   enter, clear          one-cycle button strobes
//   add_start             one-cycle launch pulse to the adder
//   add_a, add_b          operands, held stable while the add is pending
//   add_done, add_sum     adder completion strobe and result
//   display               word for the display
//   mode                  0=ENT_A 1=ENT_B 2=WAIT 3=SHOW
//   busy                  high while waiting on the adder
//   err                   sticky adder-timeout flag
module fp_entry_ctrl #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_value,
    input  logic                  enter,
    input  logic                  clear,
    output logic                  add_start,
    output logic [DIGITS*4-1:0]   add_a,
    output logic [DIGITS*4-1:0]   add_b,
    input  logic                  add_done,
    input  logic [DIGITS*4-1:0]   add_sum,
    output logic [DIGITS*4-1:0]   display,
    output logic [1:0]            mode,
    output logic                  busy,
    output logic                  err
);

    localparam int W  = DIGITS * 4;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]  QNAN     = W'(16'h7E00);

    typedef enum logic [1:0] {
        ENT_A    = 2'd0,
        ENT_B    = 2'd1,
        WAIT_ADD = 2'd2,
        SHOW     = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a, a_nxt;
    logic [W-1:0]  b, b_nxt;
    logic [W-1:0]  result, res_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
    logic          start_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENT_A;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            add_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            result    <= res_nxt;
            cnt       <= cnt_nxt;
            err       <= err_nxt;
            add_start <= start_nxt;
        end
    end

    // Digit capture is evaluated before the enter transition so a same-cycle
    // key+enter launches/advances with the updated operand.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        res_nxt   = result;
        cnt_nxt   = cnt;
        err_nxt   = err;
        start_nxt = 1'b0;
        if (clear) begin
            state_nxt = ENT_A;
            a_nxt     = '0;
            b_nxt     = '0;
            res_nxt   = '0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                ENT_A: begin
                    if (key_valid)
                        a_nxt = {a[W-5:0], key_value};
                    if (enter) begin
                        state_nxt = ENT_B;
                        b_nxt     = '0;
                    end
                end
                ENT_B: begin
                    if (key_valid)
                        b_nxt = {b[W-5:0], key_value};
                    if (enter) begin
                        state_nxt = WAIT_ADD;
                        cnt_nxt   = '0;
                        start_nxt = 1'b1;
                    end
                end
                WAIT_ADD: begin
                    // done has priority over a coincident timeout
                    if (add_done) begin
                        res_nxt   = add_sum;
                        state_nxt = SHOW;
                    end else if (cnt == CNT_LAST) begin
                        res_nxt   = QNAN;
                        err_nxt   = 1'b1;
                        state_nxt = SHOW;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (enter) begin
                        state_nxt = WAIT_ADD;
                        cnt_nxt   = '0;
                        start_nxt = 1'b1;
                    end else if (key_valid) begin
                        state_nxt = ENT_A;
                        a_nxt     = W'(key_value);
                    end
                end
                default: state_nxt = ENT_A;
            endcase
        end
    end

    always_comb begin
        display = '0;
        case (state)
            ENT_A:    display = a;
            ENT_B:    display = b;
            WAIT_ADD: display = b;
            SHOW:     display = result;
            default:  display = '0;
        endcase
    end

    assign add_a = a;
    assign add_b = b;
    assign mode  = state;
    assign busy  = (state == WAIT_ADD);

endmodule

// File: tb/tb_fp_entry_ctrl.sv
module tb_fp_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        add_start;
    logic [15:0] add_a, add_b;
    logic        add_done = 1'b0;
    logic [15:0] add_sum = '0;
    logic [15:0] display;
    logic [1:0]  mode;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [31:0] launch_q[$];

    fp_entry_ctrl #(.DIGITS(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_value(key_value),
        .enter(enter), .clear(clear), .add_start(add_start), .add_a(add_a),
        .add_b(add_b), .add_done(add_done), .add_sum(add_sum), .display(display),
        .mode(mode), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: inputs applied, edge taken, outputs settled, strobes dropped
    task automatic step(input logic kv, input logic [3:0] kval, input logic ent,
                        input logic clr, input logic dn, input logic [15:0] sum);
        key_valid = kv; key_value = kval; enter = ent; clear = clr;
        add_done = dn; add_sum = sum;
        @(posedge clk); #1;
        key_valid = 1'b0; enter = 1'b0; clear = 1'b0; add_done = 1'b0;
    endtask

    task automatic key(input logic [3:0] v);
        step(1'b1, v, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask
    task automatic press_enter();
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    endtask
    task automatic press_clear();
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    endtask
    task automatic done(input logic [15:0] s);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, s);
    endtask
    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Scoreboard side: every observed launch pulse must match the operand
    // pair queued when the launching enter was driven.
    always @(negedge clk) begin
        if (!reset && add_start === 1'b1) begin
            pulses++;
            tests++;
            assert (launch_q.size() != 0) else begin
                fails++;
                $error("FAIL launch_unexpected: observed a=%h b=%h expected no launch", add_a, add_b);
            end
            if (launch_q.size() != 0) begin
                logic [31:0] e;
                e = launch_q.pop_front();
                tests++;
                assert ({add_a, add_b} === e) else begin
                    fails++;
                    $error("FAIL launch_operands: observed %h expected %h", {add_a, add_b}, e);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mode", mode, 2'd0);
        check("rst_display", display, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_start", add_start, 1'b0);
        check("rst_a", add_a, 16'h0000);

        // operand entry and launch
        key(4'h3); key(4'hC); key(4'h0); key(4'h0);
        check("entA_display", display, 16'h3C00);
        press_enter();
        check("entB_mode", mode, 2'd1);
        check("entB_display", display, 16'h0000);
        key(4'h4); key(4'h0); key(4'h0); key(4'h0);
        launch_q.push_back({16'h3C00, 16'h4000});
        press_enter();
        check("launch_start", add_start, 1'b1);
        check("launch_mode", mode, 2'd2);
        check("launch_busy", busy, 1'b1);
        check("launch_a", add_a, 16'h3C00);
        check("launch_b", add_b, 16'h4000);
        check("wait_display", display, 16'h4000);
        idle();
        check("start_one_cycle", add_start, 1'b0);

        // completion
        done(16'h4500);
        check("show_mode", mode, 2'd3);
        check("show_display", display, 16'h4500);
        check("show_busy", busy, 1'b0);

        // re-run from SHOW, then new entry from SHOW
        launch_q.push_back({16'h3C00, 16'h4000});
        press_enter();
        check("rerun_start", add_start, 1'b1);
        check("rerun_mode", mode, 2'd2);
        done(16'h1234);
        check("rerun_display", display, 16'h1234);
        key(4'h7);
        check("show_key_mode", mode, 2'd0);
        check("show_key_display", display, 16'h0007);

        // shift-out of oldest digit
        press_clear();
        check("clr_display", display, 16'h0000);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
        check("five_digits", display, 16'h2345);

        // key+enter same cycle: digit captured before the transition
        step(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0);
        check("keyent_mode", mode, 2'd1);
        check("keyent_a", add_a, 16'h3456);
        key(4'h9);
        launch_q.push_back({16'h3456, 16'h0009});
        press_enter();
        check("t4_wait_display", display, 16'h0009);

        // timeout: 64 cycles in WAIT without done
        repeat (63) idle();
        check("timeout_edge_mode", mode, 2'd2);
        check("timeout_edge_err", err, 1'b0);
        idle();
        check("timeout_mode", mode, 2'd3);
        check("timeout_err", err, 1'b1);
        check("timeout_display", display, 16'h7E00);
        done(16'h1111);
        check("done_in_show_ignored", display, 16'h7E00);

        // err is sticky across a later successful add
        launch_q.push_back({16'h3456, 16'h0009});
        press_enter();
        done(16'h2222);
        check("sticky_display", display, 16'h2222);
        check("sticky_err", err, 1'b1);
        press_clear();
        check("clr_err", err, 1'b0);
        check("clr_mode", mode, 2'd0);
        check("clr_display2", display, 16'h0000);

        // clear coincident with done abandons the add
        key(4'h1); press_enter(); key(4'h2);
        launch_q.push_back({16'h0001, 16'h0002});
        press_enter();
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'hABCD);
        check("clrdone_mode", mode, 2'd0);
        check("clrdone_display", display, 16'h0000);
        check("clrdone_err", err, 1'b0);
        done(16'h5555);
        check("late_done_mode", mode, 2'd0);
        check("late_done_display", display, 16'h0000);

        // empty operands; done coincides with the timeout cycle, keys ignored
        press_enter();
        check("empty_entB", mode, 2'd1);
        launch_q.push_back({16'h0000, 16'h0000});
        press_enter();
        check("empty_a", add_a, 16'h0000);
        repeat (63) idle();
        check("race_wait_mode", mode, 2'd2);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 16'h4242);
        check("race_mode", mode, 2'd3);
        check("race_display", display, 16'h4242);
        check("race_err", err, 1'b0);

        idle();
        check("launch_count", pulses, 6);
        check("queue_drained", launch_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout_global: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
